// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receiver configuration shadowing, byte FIFO and error status
// Config writes wait until the line has been idle for 12 bit times before reaching the receiver.
module uart_rx_ctrl #(
   parameter int          DEPTH        = 4,
   parameter logic [5:0]  RST_PRESCALE = 6'd8,
   parameter logic        RST_PAR_EN   = 1'b1,
   parameter logic        RST_PAR_TYP  = 1'b0,
   parameter int          ERR_CNT_W    = 8
) (
   input  logic                     CLK,
   input  logic                     RSTn,
   input  logic                     cfg_wr,
   input  logic                     cfg_par_en,
   input  logic                     cfg_par_typ,
   input  logic [5:0]               cfg_prescale,
   output logic                     cfg_busy,
   input  logic                     rx_line,
   output logic                     rx_par_en,
   output logic                     rx_par_typ,
   output logic [5:0]               rx_prescale,
   input  logic [7:0]               rx_data,
   input  logic                     rx_data_vld,
   input  logic                     rx_par_err,
   input  logic                     rx_stp_err,
   input  logic                     rx_str_err,
   output logic [7:0]               m_data,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic [$clog2(DEPTH):0]   fifo_level,
   output logic                     ovf,
   output logic [ERR_CNT_W-1:0]     err_cnt,
   input  logic                     clr_stat
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {
      S_RUN   = 2'd0,
      S_PEND  = 2'd1,
      S_APPLY = 2'd2
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic        shd_ld;
   logic        apply;
   logic        shd_par_en;
   logic        shd_par_typ;
   logic [5:0]  shd_prescale;
   logic [9:0]  idle_cnt;
   logic [9:0]  idle_lim;
   logic        idle_ok;

   // A full frame is at most 12 bits, so 12 bit times of high line means nothing is in flight.
   assign idle_lim = 10'(rx_prescale) * 10'd12;
   assign idle_ok  = (idle_cnt >= idle_lim);
   assign cfg_busy = (state != S_RUN);

   always_comb begin
      state_nxt = state;
      shd_ld    = 1'b0;
      apply     = 1'b0;
      case (state)
         S_RUN: begin
            if (cfg_wr) begin
               shd_ld    = 1'b1;
               state_nxt = S_PEND;
            end
         end
         S_PEND: begin
            if (cfg_wr) begin
               shd_ld = 1'b1;
            end else if (idle_ok) begin
               state_nxt = S_APPLY;
            end
         end
         S_APPLY: begin
            apply     = 1'b1;
            state_nxt = S_RUN;
         end
         default: state_nxt = S_RUN;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         state        <= S_RUN;
         shd_par_en   <= RST_PAR_EN;
         shd_par_typ  <= RST_PAR_TYP;
         shd_prescale <= RST_PRESCALE;
         rx_par_en    <= RST_PAR_EN;
         rx_par_typ   <= RST_PAR_TYP;
         rx_prescale  <= RST_PRESCALE;
      end else begin
         state <= state_nxt;
         if (shd_ld) begin
            shd_par_en   <= cfg_par_en;
            shd_par_typ  <= cfg_par_typ;
            shd_prescale <= cfg_prescale;
         end
         if (apply) begin
            rx_par_en   <= shd_par_en;
            rx_par_typ  <= shd_par_typ;
            rx_prescale <= shd_prescale;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!RSTn || !rx_line || apply) begin
         idle_cnt <= '0;
      end else if (idle_cnt != '1) begin
         idle_cnt <= idle_cnt + 10'd1;
      end
   end

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          full;
   logic          pop;
   logic          push_ok;
   logic          drop;

   assign m_valid = (fifo_level != '0);
   assign m_data  = mem[rd_ptr];
   assign full    = (fifo_level == (AW+1)'(DEPTH));
   assign pop     = m_valid & m_ready;
   // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
   assign push_ok = rx_data_vld & (~full | pop);
   assign drop    = rx_data_vld & full & ~pop;

   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= 8'h00;
         end
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
      end else begin
         if (push_ok) begin
            mem[wr_ptr] <= rx_data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push_ok, pop})
            2'b10:   fifo_level <= fifo_level + 1'b1;
            2'b01:   fifo_level <= fifo_level - 1'b1;
            default: fifo_level <= fifo_level;
         endcase
      end
   end

   logic err_any;
   logic err_q;
   logic err_evt;

   assign err_any = rx_par_err | rx_stp_err | rx_str_err;
   assign err_evt = err_any & ~err_q;

   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_any;
      end
   end

   // Clear takes priority over any simultaneous drop or error event.
   always_ff @(posedge CLK) begin
      if (!RSTn || clr_stat) begin
         ovf     <= 1'b0;
         err_cnt <= '0;
      end else begin
         if (drop) begin
            ovf <= 1'b1;
         end
         if (err_evt && (err_cnt != '1)) begin
            err_cnt <= err_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - bench for uart_rx_ctrl with queue-based reference model
module tb_uart_rx_ctrl;

   logic        CLK = 1'b0;
   logic        RSTn;
   logic        cfg_wr;
   logic        cfg_par_en;
   logic        cfg_par_typ;
   logic [5:0]  cfg_prescale;
   logic        cfg_busy;
   logic        rx_line;
   logic        rx_par_en;
   logic        rx_par_typ;
   logic [5:0]  rx_prescale;
   logic [7:0]  rx_data;
   logic        rx_data_vld;
   logic        rx_par_err;
   logic        rx_stp_err;
   logic        rx_str_err;
   logic [7:0]  m_data;
   logic        m_valid;
   logic        m_ready;
   logic [2:0]  fifo_level;
   logic        ovf;
   logic [7:0]  err_cnt;
   logic        clr_stat;

   uart_rx_ctrl #(
      .DEPTH(4), .RST_PRESCALE(6'd8), .RST_PAR_EN(1'b1), .RST_PAR_TYP(1'b0), .ERR_CNT_W(8)
   ) dut (
      .CLK(CLK), .RSTn(RSTn),
      .cfg_wr(cfg_wr), .cfg_par_en(cfg_par_en), .cfg_par_typ(cfg_par_typ),
      .cfg_prescale(cfg_prescale), .cfg_busy(cfg_busy), .rx_line(rx_line),
      .rx_par_en(rx_par_en), .rx_par_typ(rx_par_typ), .rx_prescale(rx_prescale),
      .rx_data(rx_data), .rx_data_vld(rx_data_vld), .rx_par_err(rx_par_err),
      .rx_stp_err(rx_stp_err), .rx_str_err(rx_str_err), .m_data(m_data),
      .m_valid(m_valid), .m_ready(m_ready), .fifo_level(fifo_level), .ovf(ovf),
      .err_cnt(err_cnt), .clr_stat(clr_stat)
   );

   always #5 CLK = ~CLK;

   int n_pass  = 0;
   int n_total = 0;
   bit chk_en  = 1'b0;

   task automatic chk(input string nm, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
   endtask

   // Reference model: queue FIFO, pending/applying flags, plain integer counters.
   logic [7:0] mq[$];
   int  a_pe, a_pt, a_ps, s_pe, s_pt, s_ps;
   bit  pend, appl;
   int  idle, ecnt;
   bit  errq, movf;

   always @(posedge CLK) begin
      if (!RSTn) begin
         mq.delete();
         a_pe = 1; a_pt = 0; a_ps = 8;
         s_pe = 1; s_pt = 0; s_ps = 8;
         pend = 0; appl = 0; idle = 0; ecnt = 0; errq = 0; movf = 0;
      end else begin
         bit do_pop, drop, ev, was_appl, anyerr;
         do_pop = (mq.size() > 0) && m_ready;
         drop   = 0;
         if (rx_data_vld && mq.size() == 4 && !do_pop) drop = 1;
         if (do_pop) void'(mq.pop_front());
         if (rx_data_vld && !drop) mq.push_back(rx_data);
         if (clr_stat) movf = 0;
         else if (drop) movf = 1;
         anyerr = rx_par_err || rx_stp_err || rx_str_err;
         ev     = anyerr && !errq;
         errq   = anyerr;
         if (clr_stat) ecnt = 0;
         else if (ev && ecnt < 255) ecnt++;
         was_appl = appl;
         if (appl) begin
            a_pe = s_pe; a_pt = s_pt; a_ps = s_ps; appl = 0;
         end else if (cfg_wr) begin
            s_pe = cfg_par_en; s_pt = cfg_par_typ; s_ps = cfg_prescale; pend = 1;
         end else if (pend && idle >= 12 * a_ps) begin
            pend = 0; appl = 1;
         end
         if (!rx_line || was_appl) idle = 0;
         else if (idle < 1023) idle++;
      end
   end

   always @(negedge CLK) begin
      if (chk_en) begin
         chk("m_valid", m_valid, mq.size() > 0);
         if (mq.size() > 0) chk("m_data", m_data, mq[0]);
         chk("fifo_level", fifo_level, mq.size());
         chk("ovf", ovf, movf);
         chk("err_cnt", err_cnt, ecnt);
         chk("rx_prescale", rx_prescale, a_ps);
         chk("rx_par_en", rx_par_en, a_pe);
         chk("rx_par_typ", rx_par_typ, a_pt);
         chk("cfg_busy", cfg_busy, pend || appl);
      end
   end

   task automatic tick();
      @(negedge CLK);
   endtask

   task automatic cfg(input bit pe, input bit pt, input logic [5:0] ps);
      cfg_par_en = pe; cfg_par_typ = pt; cfg_prescale = ps; cfg_wr = 1;
      tick();
      cfg_wr = 0;
   endtask

   initial begin
      RSTn = 0; cfg_wr = 0; cfg_par_en = 0; cfg_par_typ = 0; cfg_prescale = 6'd8;
      rx_line = 1; rx_data = 0; rx_data_vld = 0; rx_par_err = 0; rx_stp_err = 0;
      rx_str_err = 0; m_ready = 0; clr_stat = 0;
      tick(); tick();
      RSTn = 1;
      chk_en = 1;
      chk("rst_m_data", m_data, 0);
      chk("rst_level", fifo_level, 0);
      chk("rst_prescale", rx_prescale, 8);
      chk("rst_par_en", rx_par_en, 1);
      chk("rst_busy", cfg_busy, 0);

      // Two pushes, then two pops
      rx_data_vld = 1; rx_data = 8'hA5; tick();
      rx_data = 8'h3C; tick();
      rx_data_vld = 0;
      chk("t1_valid", m_valid, 1);
      chk("t1_data", m_data, 8'hA5);
      chk("t1_level", fifo_level, 2);
      m_ready = 1; tick();
      chk("t1_pop2", m_data, 8'h3C);
      tick();
      chk("t1_empty", m_valid, 0);
      m_ready = 0;

      // Overflow, push+pop while full, clear
      rx_data_vld = 1;
      for (int i = 0; i < 5; i++) begin
         rx_data = 8'h11 + 8'(i); tick();
      end
      chk("t2_level", fifo_level, 4);
      chk("t2_ovf", ovf, 1);
      chk("t2_head", m_data, 8'h11);
      rx_data = 8'h16; m_ready = 1; tick();
      rx_data_vld = 0; m_ready = 0;
      chk("t2_full_pp_level", fifo_level, 4);
      chk("t2_full_pp_head", m_data, 8'h12);
      clr_stat = 1; tick(); clr_stat = 0;
      chk("t2_clr", ovf, 0);
      m_ready = 1; repeat (3) tick();
      chk("t2_last", m_data, 8'h16);
      tick(); m_ready = 0;

      // Mixed traffic exercises pointer wrap
      for (int i = 0; i < 40; i++) begin
         rx_data_vld = (i % 3) != 0; rx_data = 8'(i * 7); m_ready = (i % 2) != 0;
         tick();
      end
      rx_data_vld = 0; m_ready = 1; repeat (6) tick(); m_ready = 0;

      // Config held off by line activity, then applied after 96 idle cycles
      rx_line = 0; tick();
      cfg(0, 0, 6'd16);
      for (int i = 0; i < 6; i++) begin
         rx_line = (i % 2) != 0; repeat (20) tick();
      end
      rx_line = 0; tick();
      chk("t3_busy", cfg_busy, 1);
      chk("t3_old_ps", rx_prescale, 8);
      rx_line = 1; repeat (97) tick();
      chk("t3_apply_busy", cfg_busy, 1);
      chk("t3_apply_ps", rx_prescale, 8);
      tick();
      chk("t3_new_ps", rx_prescale, 16);
      chk("t3_new_pe", rx_par_en, 0);
      chk("t3_done", cfg_busy, 0);

      // Overwrite in PEND, write in APPLY ignored
      rx_line = 0; tick();
      cfg(1, 0, 6'd32);
      cfg(1, 1, 6'd16);
      chk("t4_busy", cfg_busy, 1);
      rx_line = 1; repeat (193) tick();
      chk("t4_in_apply", cfg_busy, 1);
      cfg(0, 0, 6'd32);
      chk("t4_ps", rx_prescale, 16);
      chk("t4_pt", rx_par_typ, 1);
      chk("t4_pe", rx_par_en, 1);
      chk("t4_run", cfg_busy, 0);
      tick();
      chk("t4_ignored", cfg_busy, 0);

      // Error events and saturation
      rx_stp_err = 1; repeat (3) tick(); rx_stp_err = 0; tick();
      repeat (2) begin
         rx_par_err = 1; tick(); rx_par_err = 0; tick();
      end
      chk("t5_cnt3", err_cnt, 3);
      repeat (300) begin
         rx_str_err = 1; tick(); rx_str_err = 0; tick();
      end
      chk("t5_sat", err_cnt, 255);
      rx_par_err = 1; clr_stat = 1; tick(); clr_stat = 0;
      chk("t5_clr_wins", err_cnt, 0);
      tick(); rx_par_err = 0;
      chk("t5_no_retrig", err_cnt, 0);
      tick();

      // Reset while PEND with data buffered
      rx_data_vld = 1; rx_data = 8'h5A; tick(); rx_data = 8'hC3; tick(); rx_data_vld = 0;
      rx_line = 0; cfg(0, 1, 6'd32);
      rx_par_err = 1; tick(); rx_par_err = 0;
      chk("t6_pre_level", fifo_level, 2);
      chk("t6_pre_busy", cfg_busy, 1);
      RSTn = 0; tick(); RSTn = 1;
      chk("t6_level", fifo_level, 0);
      chk("t6_valid", m_valid, 0);
      chk("t6_ps", rx_prescale, 8);
      chk("t6_busy", cfg_busy, 0);
      chk("t6_err", err_cnt, 0);
      rx_line = 1; repeat (120) tick();
      chk("t6_discarded", rx_prescale, 8);

      chk_en = 0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
